// File: rtl/chroma_cline_req_sequencer.sv
// Expands one chroma reference-block descriptor into the cache-line
// coordinates it touches, one per cycle in raster order, for the chroma
// tag-lookup stage.
//
// state | meaning
// IDLE  | waiting for a descriptor; blk_ready_out high
// ISSUE | presenting line requests until the last one is accepted
module chroma_cline_req_sequencer #(
    parameter int C_L_H_SIZE_C = 3,
    parameter int C_L_V_SIZE_C = 2,
    parameter int X_ADDR_WDTH  = 11,
    parameter int Y_ADDR_WDTH  = 11
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              blk_valid_in,
    output logic                              blk_ready_out,
    input  logic [X_ADDR_WDTH-1:0]            start_x_in,
    input  logic [Y_ADDR_WDTH-1:0]            start_y_in,
    input  logic [1:0]                        delta_x_in,
    input  logic [1:0]                        delta_y_in,
    output logic                              line_valid_out,
    input  logic                              line_ready_in,
    output logic [X_ADDR_WDTH-C_L_H_SIZE_C-1:0] line_x_out,
    output logic [Y_ADDR_WDTH-C_L_V_SIZE_C-1:0] line_y_out,
    output logic [3:0]                        line_idx_out,
    output logic                              line_last_out,
    output logic                              err_out
);

    localparam int LXW = X_ADDR_WDTH - C_L_H_SIZE_C;
    localparam int LYW = Y_ADDR_WDTH - C_L_V_SIZE_C;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LXW-1:0]   base_x_q, base_x_d;
    logic [LYW-1:0]   base_y_q, base_y_d;
    logic [1:0]       nx_q, nx_d;
    logic [1:0]       ny_q, ny_d;
    logic [1:0]       cx_q, cx_d;
    logic [1:0]       cy_q, cy_d;
    logic             valid_q, valid_d;
    logic [LXW-1:0]   line_x_q, line_x_d;
    logic [LYW-1:0]   line_y_q, line_y_d;
    logic [3:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic [1:0]       nx_in, ny_in;
    logic [LXW-1:0]   start_cx;
    logic [LYW-1:0]   start_cy;

    // Descriptor decode: a delta of 3 is out of range and clamps to 2.
    always_comb begin
        nx_in    = (delta_x_in == 2'd3) ? 2'd2 : delta_x_in;
        ny_in    = (delta_y_in == 2'd3) ? 2'd2 : delta_y_in;
        start_cx = LXW'(start_x_in >> C_L_H_SIZE_C);
        start_cy = LYW'(start_y_in >> C_L_V_SIZE_C);
    end

    // Next-state and next-output logic; outputs are precomputed so they
    // leave the block straight from flops.
    always_comb begin
        state_d  = state_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        valid_d  = valid_q;
        line_x_d = line_x_q;
        line_y_d = line_y_q;
        idx_d    = idx_q;
        last_d   = last_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (blk_valid_in) begin
                    state_d  = ISSUE;
                    base_x_d = start_cx;
                    base_y_d = start_cy;
                    nx_d     = nx_in;
                    ny_d     = ny_in;
                    cx_d     = 2'd0;
                    cy_d     = 2'd0;
                    valid_d  = 1'b1;
                    line_x_d = start_cx;
                    line_y_d = start_cy;
                    idx_d    = 4'd0;
                    last_d   = (nx_in == 2'd0) && (ny_in == 2'd0);
                    err_d    = (delta_x_in == 2'd3) || (delta_y_in == 2'd3);
                end
            end
            ISSUE: begin
                if (line_ready_in) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        if (cx_q < nx_q) begin
                            cx_d = cx_q + 2'd1;
                        end else begin
                            cx_d = 2'd0;
                            cy_d = cy_q + 2'd1;
                        end
                        line_x_d = base_x_q + LXW'(cx_d);
                        line_y_d = base_y_q + LYW'(cy_d);
                        idx_d    = idx_q + 4'd1;
                        last_d   = (cx_d == nx_q) && (cy_d == ny_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            base_x_q <= '0;
            base_y_q <= '0;
            nx_q     <= '0;
            ny_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            valid_q  <= 1'b0;
            line_x_q <= '0;
            line_y_q <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            valid_q  <= valid_d;
            line_x_q <= line_x_d;
            line_y_q <= line_y_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign blk_ready_out  = (state_q == IDLE);
    assign line_valid_out = valid_q;
    assign line_x_out     = line_x_q;
    assign line_y_out     = line_y_q;
    assign line_idx_out   = idx_q;
    assign line_last_out  = last_q;
    assign err_out        = err_q;

endmodule

// File: tb/tb_chroma_cline_req_sequencer.sv
// Bench for the chroma cache-line request sequencer: directed blocks from
// the test plan followed by randomized descriptors and backpressure.
module tb_chroma_cline_req_sequencer;

    localparam int HS  = 3;
    localparam int VS  = 2;
    localparam int XW  = 11;
    localparam int YW  = 11;
    localparam int LXW = XW - HS;
    localparam int LYW = YW - VS;

    logic            clk;
    logic            reset;
    logic            blk_valid_in;
    logic            blk_ready_out;
    logic [XW-1:0]   start_x_in;
    logic [YW-1:0]   start_y_in;
    logic [1:0]      delta_x_in;
    logic [1:0]      delta_y_in;
    logic            line_valid_out;
    logic            line_ready_in;
    logic [LXW-1:0]  line_x_out;
    logic [LYW-1:0]  line_y_out;
    logic [3:0]      line_idx_out;
    logic            line_last_out;
    logic            err_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int x;
        int y;
        int idx;
        int last;
    } line_t;

    line_t exp_q[$];

    chroma_cline_req_sequencer #(
        .C_L_H_SIZE_C(HS),
        .C_L_V_SIZE_C(VS),
        .X_ADDR_WDTH (XW),
        .Y_ADDR_WDTH (YW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .blk_valid_in  (blk_valid_in),
        .blk_ready_out (blk_ready_out),
        .start_x_in    (start_x_in),
        .start_y_in    (start_y_in),
        .delta_x_in    (delta_x_in),
        .delta_y_in    (delta_y_in),
        .line_valid_out(line_valid_out),
        .line_ready_in (line_ready_in),
        .line_x_out    (line_x_out),
        .line_y_out    (line_y_out),
        .line_idx_out  (line_idx_out),
        .line_last_out (line_last_out),
        .err_out       (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference: a block covers every cache line from the start line to
    // start+delta in each direction, row by row, coordinates wrapping.
    task automatic build_expect(input int sx, input int sy, input int dx, input int dy);
        int nx, ny, k;
        nx = (dx > 2) ? 2 : dx;
        ny = (dy > 2) ? 2 : dy;
        k  = 0;
        exp_q.delete();
        for (int y = 0; y <= ny; y++) begin
            for (int x = 0; x <= nx; x++) begin
                line_t l;
                l.x    = ((sx >> HS) + x) % (1 << LXW);
                l.y    = ((sy >> VS) + y) % (1 << LYW);
                l.idx  = k;
                l.last = (k == (nx + 1) * (ny + 1) - 1) ? 1 : 0;
                exp_q.push_back(l);
                k++;
            end
        end
    endtask

    // mode 0: random ready, 1: ready held high, 2: ready pattern 1,0,0,...
    // abort_after >= 0 asserts reset while that line index is presented.
    task automatic send_block(input int sx, input int sy, input int dx, input int dy,
                              input int mode, input int abort_after);
        int   budget, hs;
        bit   first, aborted, rdy;
        logic errexp;
        budget = 0;
        while (!blk_ready_out && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("blk_ready_before", blk_ready_out, 1);
        blk_valid_in = 1'b1;
        start_x_in   = XW'(sx);
        start_y_in   = YW'(sy);
        delta_x_in   = 2'(dx);
        delta_y_in   = 2'(dy);
        line_ready_in = 1'b0;
        @(negedge clk);
        // Scramble descriptor inputs: they must only matter on the accept edge.
        blk_valid_in = 1'b0;
        start_x_in   = XW'($urandom);
        start_y_in   = YW'($urandom);
        delta_x_in   = 2'($urandom);
        delta_y_in   = 2'($urandom);
        build_expect(sx, sy, dx, dy);
        errexp  = (dx == 3) || (dy == 3);
        hs      = 0;
        budget  = 0;
        first   = 1'b1;
        aborted = 1'b0;
        while (exp_q.size() > 0) begin
            if (budget > 200) begin
                chk("line_timeout", 0, 1);
                exp_q.delete();
                break;
            end
            chk("err_out", err_out, first ? errexp : 1'b0);
            first = 1'b0;
            chk("line_valid", line_valid_out, 1);
            chk("blk_ready_busy", blk_ready_out, 0);
            chk("line_x", 32'(line_x_out), exp_q[0].x);
            chk("line_y", 32'(line_y_out), exp_q[0].y);
            chk("line_idx", 32'(line_idx_out), exp_q[0].idx);
            chk("line_last", line_last_out, exp_q[0].last);
            if (hs == abort_after) begin
                reset         = 1'b1;
                line_ready_in = 1'b1;
                @(negedge clk);
                reset         = 1'b0;
                line_ready_in = 1'b0;
                chk("rst_line_valid", line_valid_out, 0);
                chk("rst_blk_ready", blk_ready_out, 1);
                exp_q.delete();
                aborted = 1'b1;
                break;
            end
            case (mode)
                1:       rdy = 1'b1;
                2:       rdy = (budget % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            line_ready_in = rdy;
            @(negedge clk);
            budget++;
            if (rdy) begin
                void'(exp_q.pop_front());
                hs++;
            end
        end
        line_ready_in = 1'($urandom_range(0, 1));
        if (!aborted) begin
            chk("done_line_valid", line_valid_out, 0);
            chk("done_blk_ready", blk_ready_out, 1);
            chk("done_err", err_out, 0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        blk_valid_in  = 1'b1;
        line_ready_in = 1'b0;
        start_x_in    = '0;
        start_y_in    = '0;
        delta_x_in    = '0;
        delta_y_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", line_valid_out, 0);
        chk("rst_x", 32'(line_x_out), 0);
        chk("rst_y", 32'(line_y_out), 0);
        chk("rst_idx", 32'(line_idx_out), 0);
        chk("rst_last", line_last_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_ready", blk_ready_out, 1);
        reset        = 1'b0;
        blk_valid_in = 1'b0;
        @(negedge clk);
        chk("idle_valid", line_valid_out, 0);

        send_block(5, 3, 0, 0, 1, -1);
        send_block(14, 7, 2, 2, 1, -1);
        send_block(20, 10, 1, 1, 2, -1);
        send_block(2047, 0, 1, 0, 1, -1);
        send_block(14, 7, 2, 2, 1, 2);
        send_block(5, 3, 0, 0, 1, -1);
        send_block(0, 0, 3, 0, 1, -1);
        send_block(100, 2047, 1, 3, 0, -1);

        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("gap_valid", line_valid_out, 0);
            end
            send_block(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
